// File: rtl/residual_echo_monitor_pkg.sv
// Shared definitions for the residual echo monitor and related monitors.
// Contents: FSM state encoding, default counter width, sample width and a
// two's-complement magnitude helper.
package residual_echo_monitor_pkg;

    localparam int CW_DEFAULT = 13;
    localparam int SAMPLE_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_REPORT = 2'd3
    } rem_state_t;

    // Magnitude as unsigned: -32768 maps to 32768 (0x8000), which fits in
    // 16 unsigned bits, so no saturation is needed.
    function automatic logic [SAMPLE_W-1:0] abs16(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = ~x + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        return x[SAMPLE_W-1] ? neg : x;
    endfunction

endpackage

// File: rtl/residual_echo_monitor_abs_peak.sv
// sig16b_abs_peak: combinational |x| of a 16-bit two's-complement sample and
// running-maximum update.
// Ports:
//   sample    in  16  two's-complement sample
//   peak_in   in  16  current running peak (unsigned)
//   abs_val   out 16  |sample| (unsigned)
//   peak_out  out 16  max(peak_in, abs_val)
module sig16b_abs_peak
    import residual_echo_monitor_pkg::*;
(
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] peak_in,
    output logic [SAMPLE_W-1:0] abs_val,
    output logic [SAMPLE_W-1:0] peak_out
);

    always_comb begin
        abs_val  = abs16(sample);
        peak_out = (abs_val > peak_in) ? abs_val : peak_in;
    end

endmodule

// File: rtl/residual_echo_monitor.sv
// Residual echo monitor: takes one residual sample per sampling cycle,
// accumulates windowed abs-sum / peak and flags convergence once the window
// peak stays at or below threshold for CONV_WINDOWS consecutive windows.
// Ports:
//   clk_operation           in   operation clock
//   rst                     in   synchronous active-high reset
//   enable                  in   monitor runs while high
//   sampling_cycle_counter  in   free-running sample-phase counter (CW bits)
//   sig16b_without_echo     in   residual sample, two's complement
//   threshold               in   unsigned peak limit
//   window_valid            out  one-cycle pulse per completed window
//   window_abs_sum          out  sum of |x| over last window
//   window_mean             out  window_abs_sum >> WIN_LOG2 (truncating)
//   window_peak             out  max |x| over last window
//   quiet_run               out  consecutive quiet windows, saturating
//   converged               out  quiet_run == CONV_WINDOWS
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | monitor disabled, partial window and quiet run discarded
// ST_ARMED  | waiting for capture slot with armed flag set
// ST_ACCUM  | fold captured sample into sum/peak, advance sample index
// ST_REPORT | publish window results, update quiet run, clear accumulators
module residual_echo_monitor
    import residual_echo_monitor_pkg::*;
#(
    parameter int CW           = CW_DEFAULT,
    parameter int CAPTURE_SLOT = 3900,
    parameter int WIN_LOG2     = 4,
    parameter int CONV_WINDOWS = 4
) (
    input  logic                         clk_operation,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CW-1:0]                sampling_cycle_counter,
    input  logic [SAMPLE_W-1:0]          sig16b_without_echo,
    input  logic [SAMPLE_W-1:0]          threshold,
    output logic                         window_valid,
    output logic [SAMPLE_W+WIN_LOG2-1:0] window_abs_sum,
    output logic [SAMPLE_W-1:0]          window_mean,
    output logic [SAMPLE_W-1:0]          window_peak,
    output logic [3:0]                   quiet_run,
    output logic                         converged
);

    localparam int                   SUM_W    = SAMPLE_W + WIN_LOG2;
    localparam logic [CW-1:0]        SLOT     = CW'(CAPTURE_SLOT);
    localparam logic [WIN_LOG2-1:0]  IDX_LAST = '1;
    localparam logic [3:0]           CONV_C   = 4'(CONV_WINDOWS);

    rem_state_t            state_q, state_d;
    logic                  armed_q;
    logic [SAMPLE_W-1:0]   sample_q;
    logic [SUM_W-1:0]      acc_sum;
    logic [SAMPLE_W-1:0]   acc_peak;
    logic [WIN_LOG2-1:0]   idx;

    logic                  do_capture, do_accum, do_report, do_discard;
    logic                  capture_ok;
    logic [SAMPLE_W-1:0]   abs_val, peak_next;
    logic [3:0]            quiet_next;

    sig16b_abs_peak u_abs_peak (
        .sample   (sample_q),
        .peak_in  (acc_peak),
        .abs_val  (abs_val),
        .peak_out (peak_next)
    );

    // Armed flag guarantees one capture per sampling cycle even when the
    // counter skips values or sits past the slot for several clocks.
    assign capture_ok = armed_q && (sampling_cycle_counter >= SLOT);

    always_ff @(posedge clk_operation) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_capture = 1'b0;
        do_accum   = 1'b0;
        do_report  = 1'b0;
        do_discard = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
                else        do_discard = 1'b1;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    do_discard = 1'b1;
                end else if (capture_ok) begin
                    do_capture = 1'b1;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    do_discard = 1'b1;
                end else begin
                    do_accum = 1'b1;
                    state_d  = (idx == IDX_LAST) ? ST_REPORT : ST_ARMED;
                end
            end
            ST_REPORT: begin
                // A report in flight always completes, even if enable fell.
                do_report = 1'b1;
                state_d   = enable ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        quiet_next = 4'd0;
        if (acc_peak <= threshold)
            quiet_next = (quiet_run < CONV_C) ? quiet_run + 4'd1 : CONV_C;
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            armed_q        <= 1'b0;
            sample_q       <= '0;
            acc_sum        <= '0;
            acc_peak       <= '0;
            idx            <= '0;
            window_valid   <= 1'b0;
            window_abs_sum <= '0;
            window_mean    <= '0;
            window_peak    <= '0;
            quiet_run      <= '0;
            converged      <= 1'b0;
        end else begin
            window_valid <= do_report;

            if (sampling_cycle_counter < SLOT) armed_q <= 1'b1;
            else if (do_capture)               armed_q <= 1'b0;

            if (do_capture) sample_q <= sig16b_without_echo;

            if (do_accum) begin
                acc_sum  <= acc_sum + SUM_W'(abs_val);
                acc_peak <= peak_next;
                idx      <= idx + 1'b1;
            end

            if (do_report) begin
                window_abs_sum <= acc_sum;
                window_mean    <= acc_sum[SUM_W-1:WIN_LOG2];
                window_peak    <= acc_peak;
                quiet_run      <= quiet_next;
                converged      <= (quiet_next == CONV_C);
                acc_sum        <= '0;
                acc_peak       <= '0;
                idx            <= '0;
            end

            if (do_discard) begin
                acc_sum   <= '0;
                acc_peak  <= '0;
                idx       <= '0;
                quiet_run <= '0;
                converged <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_residual_echo_monitor.sv
module tb_residual_echo_monitor;

    localparam int CW = 13;
    localparam int SLOT = 100;
    localparam int WL2 = 2;
    localparam int CONV = 2;

    logic              clk_operation = 1'b0;
    logic              rst;
    logic              enable;
    logic [CW-1:0]     sampling_cycle_counter;
    logic [15:0]       sig16b_without_echo;
    logic [15:0]       threshold;
    logic              window_valid;
    logic [16+WL2-1:0] window_abs_sum;
    logic [15:0]       window_mean;
    logic [15:0]       window_peak;
    logic [3:0]        quiet_run;
    logic              converged;

    residual_echo_monitor #(
        .CW(CW), .CAPTURE_SLOT(SLOT), .WIN_LOG2(WL2), .CONV_WINDOWS(CONV)
    ) dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .enable                 (enable),
        .sampling_cycle_counter (sampling_cycle_counter),
        .sig16b_without_echo    (sig16b_without_echo),
        .threshold              (threshold),
        .window_valid           (window_valid),
        .window_abs_sum         (window_abs_sum),
        .window_mean            (window_mean),
        .window_peak            (window_peak),
        .quiet_run              (quiet_run),
        .converged              (converged)
    );

    always #5 clk_operation = ~clk_operation;

    typedef struct {
        logic [3:0][15:0] s;
        logic [15:0]      thr;
        int               sum;
        int               mean;
        int               peak;
        int               quiet;
        int               conv;
    } vec_t;

    vec_t vecs[8];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;
    int   cap_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_operation);
        #1;
        cyc++;
        if (window_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
    endtask

    task automatic sample_cycle(input logic [15:0] v);
        sig16b_without_echo = v;
        sampling_cycle_counter = 13'd50;  tick();
        sampling_cycle_counter = 13'd100; tick();
        cap_cyc = cyc;
        sampling_cycle_counter = 13'd101; tick();
        sampling_cycle_counter = 13'd102; tick();
    endtask

    // Counter jumps 99 -> 101 and stays past the slot for several clocks.
    task automatic skip_cycle(input logic [15:0] v);
        sig16b_without_echo = v;
        sampling_cycle_counter = 13'd99;  tick();
        sampling_cycle_counter = 13'd101; tick();
        sampling_cycle_counter = 13'd103; tick();
        sampling_cycle_counter = 13'd105; tick();
        sampling_cycle_counter = 13'd107; tick();
    endtask

    task automatic check_outputs(input string tag, input int sum, input int mean,
                                 input int peak, input int quiet, input int conv);
        check({tag, ".sum"},   32'(window_abs_sum), 32'(sum));
        check({tag, ".mean"},  32'(window_mean),    32'(mean));
        check({tag, ".peak"},  32'(window_peak),    32'(peak));
        check({tag, ".quiet"}, 32'(quiet_run),      32'(quiet));
        check({tag, ".conv"},  32'(converged),      32'(conv));
    endtask

    initial begin
        int v0;
        vecs[0] = '{s:{16'hFFFF, 16'd2, 16'hFFFB, 16'd3}, thr:16'd8, sum:11, mean:2, peak:5, quiet:1, conv:0};
        vecs[1] = '{s:{16'd1, 16'hFFFC, 16'd0, 16'd5}, thr:16'd8, sum:10, mean:2, peak:5, quiet:2, conv:1};
        vecs[2] = '{s:{16'd0, 16'd0, 16'd9, 16'd1}, thr:16'd8, sum:10, mean:2, peak:9, quiet:0, conv:0};
        vecs[3] = '{s:{16'd0, 16'd0, 16'h8000, 16'd0}, thr:16'hFFFF, sum:32768, mean:8192, peak:32768, quiet:1, conv:0};
        vecs[4] = '{s:{16'hFFF8, 16'd8, 16'hFFF8, 16'd8}, thr:16'd8, sum:32, mean:8, peak:8, quiet:2, conv:1};
        vecs[5] = '{s:{16'd7, 16'd7, 16'd7, 16'd7}, thr:16'd7, sum:28, mean:7, peak:7, quiet:2, conv:1};
        vecs[6] = '{s:{16'h8000, 16'h8000, 16'h8000, 16'h8000}, thr:16'd0, sum:131072, mean:32768, peak:32768, quiet:0, conv:0};
        vecs[7] = '{s:{16'hFFFF, 16'd1, 16'd32767, 16'h8001}, thr:16'd32767, sum:65536, mean:16384, peak:32767, quiet:1, conv:0};

        rst = 1'b1;
        enable = 1'b0;
        sampling_cycle_counter = '0;
        sig16b_without_echo = '0;
        threshold = '0;
        repeat (5) tick();
        check("rst.valid", 32'(window_valid), 32'd0);
        check_outputs("rst", 0, 0, 0, 0, 0);

        // Disabled monitor: sampling cycles run but nothing is captured.
        rst = 1'b0;
        sample_cycle(16'd123);
        sample_cycle(16'hFF00);
        check("idle.nvalid", 32'(n_valid), 32'd0);
        check_outputs("idle", 0, 0, 0, 0, 0);

        enable = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            threshold = vecs[i].thr;
            for (int k = 0; k < 4; k++) sample_cycle(vecs[i].s[k]);
            check($sformatf("v%0d.nvalid", i), 32'(n_valid - v0), 32'd1);
            check($sformatf("v%0d.latency", i), 32'(last_valid_cyc - cap_cyc), 32'd2);
            check_outputs($sformatf("v%0d", i), vecs[i].sum, vecs[i].mean,
                          vecs[i].peak, vecs[i].quiet, vecs[i].conv);
        end

        // Held residual across a skipped-counter cycle counts once: 4 x 3 = 12.
        v0 = n_valid;
        threshold = 16'd8;
        for (int k = 0; k < 4; k++) skip_cycle(16'd3);
        check("skip.nvalid", 32'(n_valid - v0), 32'd1);
        check_outputs("skip", 12, 3, 3, 2, 1);

        // Enable drop after 2 captures: partial window discarded, quiet run reset.
        v0 = n_valid;
        sample_cycle(16'd1);
        sample_cycle(16'd1);
        enable = 1'b0;
        tick();
        tick();
        check_outputs("drop", 12, 3, 3, 0, 0);
        enable = 1'b1;
        tick();
        sample_cycle(16'd2);
        sample_cycle(16'd2);
        sample_cycle(16'd2);
        check("drop.partial", 32'(n_valid - v0), 32'd0);
        sample_cycle(16'hFFFE);
        check("drop.nvalid", 32'(n_valid - v0), 32'd1);
        check_outputs("fresh", 8, 2, 2, 1, 0);

        // Reset mid-window: everything cleared, no report.
        v0 = n_valid;
        sample_cycle(16'd4);
        sample_cycle(16'd4);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sample_cycle(16'd4);
        sample_cycle(16'd4);
        check("midrst.nvalid", 32'(n_valid - v0), 32'd0);
        check_outputs("midrst", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
